// File: rtl/ps2_receiver_if.sv
// Signal bundle between a PS/2 line/consumer side and the ps2_receiver core.
// The master drives the pins and pop request; the slave (receiver) returns scan codes and status.
interface ps2_receiver_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   modport master (
      output ps2_clk,
      output ps2_data,
      output nextdata_n,
      input  data,
      input  ready,
      input  overflow,
      input  frame_err
   );

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      input  nextdata_n,
      output data,
      output ready,
      output overflow,
      output frame_err
   );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 frame deserialiser with start/parity/stop checking, mid-frame timeout and a
// small scan-code FIFO popped by an active-low acknowledge.
module ps2_receiver #(
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned TIMEOUT = 5000
) (
   input  logic          clk,
   input  logic          clrn,
   ps2_receiver_if.slave ps2_if
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned IW    = $clog2(TIMEOUT + 1);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        sclk_q;
   logic [1:0]        sdat_q;
   logic [3:0]        cnt_q, cnt_d;
   logic [9:0]        shift_q, shift_d;
   logic [IW-1:0]     idle_q, idle_d;
   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
   logic [7:0]        fifo_q [DEPTH];
   logic [7:0]        fifo_d [DEPTH];
   logic              overflow_q, overflow_d;
   logic              frame_err_q, frame_err_d;

   logic fall;
   logic data_sync;
   logic frame_ok;
   logic full;
   logic ready;
   logic pop;
   logic wr_en;
   logic drop;

   assign fall      = sclk_q[2] & ~sclk_q[1];
   assign data_sync = sdat_q[1];
   // Stop bit is taken straight from the line on the 11th edge, never stored.
   assign frame_ok  = ~shift_q[0] & data_sync & (^shift_q[9:1]);
   assign ready     = (w_ptr_q != r_ptr_q);
   assign full      = ((w_ptr_q + ADDR_W'(1)) == r_ptr_q);
   assign pop       = ready & ~ps2_if.nextdata_n;

   assign ps2_if.data      = fifo_q[r_ptr_q];
   assign ps2_if.ready     = ready;
   assign ps2_if.overflow  = overflow_q;
   assign ps2_if.frame_err = frame_err_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      idle_d      = idle_q;
      frame_err_d = 1'b0;
      wr_en       = 1'b0;
      drop        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            idle_d = '0;
            if (fall) begin
               shift_d[0] = data_sync;
               cnt_d      = 4'd1;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (fall) begin
               idle_d = '0;
               if (cnt_q == 4'd10) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
                  if (!frame_ok) begin
                     frame_err_d = 1'b1;
                  end else if (full) begin
                     drop = 1'b1;
                  end else begin
                     wr_en = 1'b1;
                  end
               end else begin
                  shift_d[cnt_q] = data_sync;
                  cnt_d          = cnt_q + 4'd1;
               end
            end else if (idle_q == IW'(TIMEOUT)) begin
               cnt_d       = '0;
               idle_d      = '0;
               frame_err_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               idle_d = idle_q + IW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idle_d  = '0;
         end
      endcase
   end

   // Full is judged on the pre-update pointers, so a concurrent pop never rescues a drop.
   always_comb begin
      fifo_d     = fifo_q;
      w_ptr_d    = w_ptr_q;
      r_ptr_d    = r_ptr_q;
      overflow_d = overflow_q;
      if (wr_en) begin
         fifo_d[w_ptr_q] = shift_q[8:1];
         w_ptr_d         = w_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
         r_ptr_d    = r_ptr_q + ADDR_W'(1);
         overflow_d = 1'b0;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q     <= ST_IDLE;
         sclk_q      <= '1;
         sdat_q      <= '1;
         cnt_q       <= '0;
         shift_q     <= '0;
         idle_q      <= '0;
         w_ptr_q     <= '0;
         r_ptr_q     <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         sclk_q      <= {sclk_q[1:0], ps2_if.ps2_clk};
         sdat_q      <= {sdat_q[0], ps2_if.ps2_data};
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         idle_q      <= idle_d;
         w_ptr_q     <= w_ptr_d;
         r_ptr_q     <= r_ptr_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= fifo_d[i];
         end
      end
   end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frames, break codes, bad frames, overflow,
// timeout, mid-frame reset and a write/pop collision.
module tb_ps2_receiver;

   localparam int unsigned TMO  = 200;
   localparam int unsigned HALF = 20;

   logic clk;
   logic clrn;
   int   tests;
   int   fails;
   int   ferr_hi;
   int   ferr_rise;
   logic ferr_prev;
   logic [7:0] popq [$];

   ps2_receiver_if bif ();

   ps2_receiver #(
      .ADDR_W  (3),
      .TIMEOUT (TMO)
   ) dut (
      .clk    (clk),
      .clrn   (clrn),
      .ps2_if (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (bif.frame_err === 1'b1) ferr_hi++;
      if (bif.frame_err === 1'b1 && ferr_prev !== 1'b1) ferr_rise++;
      ferr_prev = bif.frame_err;
      if (clrn && bif.ready && !bif.nextdata_n) popq.push_back(bif.data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] b, input logic badpar, input logic stop);
      logic par;
      par = ~(^b) ^ badpar;
      return {stop, par, b, 1'b0};
   endfunction

   task automatic ps2_bits(input logic [10:0] bits, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         bif.ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         bif.ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         bif.ps2_clk = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic badpar, input logic stop);
      ps2_bits(mkframe(b, badpar, stop), 11);
      bif.ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic pop1();
      @(negedge clk);
      bif.nextdata_n = 1'b0;
      @(negedge clk);
      bif.nextdata_n = 1'b1;
   endtask

   initial begin
      int e0;
      int r0;
      logic [10:0] fr;
      tests = 0;
      fails = 0;
      ferr_hi = 0;
      ferr_rise = 0;
      ferr_prev = 1'b0;
      bif.ps2_clk = 1'b1;
      bif.ps2_data = 1'b1;
      bif.nextdata_n = 1'b1;
      clrn = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_ready", 32'(bif.ready), 32'd0);
      check("rst_data", 32'(bif.data), 32'h00);
      check("rst_ovf", 32'(bif.overflow), 32'd0);
      check("rst_ferr", 32'(bif.frame_err), 32'd0);
      clrn = 1'b1;
      repeat (4) @(negedge clk);

      // single frame
      send(8'h1C, 1'b0, 1'b1);
      check("single_ready", 32'(bif.ready), 32'd1);
      check("single_data", 32'(bif.data), 32'h1C);
      pop1();
      check("single_pop_ready", 32'(bif.ready), 32'd0);

      // break sequence
      send(8'hF0, 1'b0, 1'b1);
      send(8'h1C, 1'b0, 1'b1);
      check("brk_data0", 32'(bif.data), 32'hF0);
      pop1();
      check("brk_data1", 32'(bif.data), 32'h1C);
      check("brk_ready1", 32'(bif.ready), 32'd1);
      pop1();
      check("brk_ready2", 32'(bif.ready), 32'd0);

      // bad frames: parity error, then stop error
      e0 = ferr_rise;
      r0 = ferr_hi;
      send(8'h1C, 1'b1, 1'b1);
      send(8'h1C, 1'b0, 1'b0);
      check("bad_ferr_pulses", 32'(ferr_rise - e0), 32'd2);
      check("bad_ferr_width", 32'(ferr_hi - r0), 32'd2);
      check("bad_ready", 32'(bif.ready), 32'd0);
      check("bad_data", 32'(bif.data), 32'h00);

      // overflow: 8 frames into a 7-byte FIFO
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b1);
      check("ovf_flag", 32'(bif.overflow), 32'd1);
      check("ovf_head", 32'(bif.data), 32'h01);
      for (int i = 1; i <= 7; i++) begin
         check("ovf_pop_data", 32'(bif.data), 32'(i));
         pop1();
         if (i == 1) check("ovf_clear", 32'(bif.overflow), 32'd0);
      end
      check("ovf_ready_end", 32'(bif.ready), 32'd0);

      // timeout after 5 bits
      e0 = ferr_rise;
      fr = mkframe(8'h5A, 1'b0, 1'b1);
      ps2_bits(fr, 5);
      repeat (TMO + 10) @(negedge clk);
      check("tmo_ferr", 32'(ferr_rise - e0), 32'd1);
      check("tmo_ready", 32'(bif.ready), 32'd0);
      send(8'h5A, 1'b0, 1'b1);
      check("tmo_next_data", 32'(bif.data), 32'h5A);
      pop1();

      // reset mid-frame with a byte queued
      send(8'h77, 1'b0, 1'b1);
      check("mrst_pre", 32'(bif.data), 32'h77);
      e0 = ferr_rise;
      fr = mkframe(8'h33, 1'b0, 1'b1);
      ps2_bits(fr, 4);
      clrn = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
      check("mrst_ready", 32'(bif.ready), 32'd0);
      check("mrst_data", 32'(bif.data), 32'h00);
      check("mrst_ovf", 32'(bif.overflow), 32'd0);
      repeat (TMO + 10) @(negedge clk);
      check("mrst_no_ferr", 32'(ferr_rise - e0), 32'd0);
      send(8'h29, 1'b0, 1'b1);
      check("mrst_next_data", 32'(bif.data), 32'h29);
      pop1();
      check("mrst_next_empty", 32'(bif.ready), 32'd0);

      // write/pop collision: pops span the 11th edge
      send(8'h11, 1'b0, 1'b1);
      send(8'h22, 1'b0, 1'b1);
      send(8'h33, 1'b0, 1'b1);
      popq.delete();
      fr = mkframe(8'h44, 1'b0, 1'b1);
      ps2_bits(fr, 10);
      bif.ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      bif.ps2_clk = 1'b0;
      @(negedge clk);
      bif.nextdata_n = 1'b0;
      repeat (10) @(negedge clk);
      bif.nextdata_n = 1'b1;
      repeat (HALF) @(negedge clk);
      bif.ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      check("coll_count", 32'(popq.size()), 32'd4);
      if (popq.size() == 4) begin
         check("coll_b0", 32'(popq[0]), 32'h11);
         check("coll_b1", 32'(popq[1]), 32'h22);
         check("coll_b2", 32'(popq[2]), 32'h33);
         check("coll_b3", 32'(popq[3]), 32'h44);
      end
      check("coll_ready", 32'(bif.ready), 32'd0);
      check("coll_ovf", 32'(bif.overflow), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
